// File: rtl/ahb_dffram_pkg.sv
// Shared encodings for the AHB-Lite DFFRAM front end.
// Bus transfer/size codes and the controller state type.
package ahb_dffram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RAW
  } state_t;

endpackage

// File: rtl/ahb_byte_lanes.sv
// AHB byte-lane decoder: transfer size and low address bits to lane mask.
// Sizes above a word are treated as a full word.
module ahb_byte_lanes
  import ahb_dffram_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] lanes
);

  always_comb begin
    lanes = 4'b1111;
    case (hsize)
      HSIZE_BYTE: lanes = 4'b0001 << addr;
      HSIZE_HALF: lanes = 4'b0011 << {addr[1], 1'b0};
      default:    lanes = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_dffram_ctrl.sv
// AHB-Lite slave front end for a single-port registered-read DFFRAM.
// Reads issue in the address phase; a read behind a write costs one wait.
module ahb_dffram_ctrl
  import ahb_dffram_pkg::*;
#(
  parameter  int COLS    = 1,
  localparam int A_WIDTH = 8 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               HSEL,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HADDR,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic [31:0]        HRDATA,
  output logic               HRESP,
  output logic               RAM_EN,
  output logic [3:0]         RAM_WE,
  output logic [A_WIDTH-1:0] RAM_A,
  output logic [31:0]        RAM_Di,
  input  logic [31:0]        RAM_Do
);

  state_t               state;
  state_t               state_n;
  logic [A_WIDTH-1:0]   addr_q;
  logic                 write_q;
  logic [3:0]           lanes_q;
  logic [3:0]           lanes;
  logic [A_WIDTH-1:0]   haddr_w;
  logic                 accept;
  logic                 unused_ok;

  assign unused_ok = ^{HADDR[31:A_WIDTH+2], HTRANS[0]};

  ahb_byte_lanes u_lanes (
    .hsize (HSIZE),
    .addr  (HADDR[1:0]),
    .lanes (lanes)
  );

  assign haddr_w   = HADDR[A_WIDTH+1:2];
  assign HREADYOUT = (state != ST_RAW);
  assign HRESP     = 1'b0;
  assign RAM_Di    = HWDATA;

  // Gated by our own ready and by reset so nothing reaches the RAM
  // while the controller is stalled or held in reset.
  assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      lanes_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= haddr_w;
        write_q <= HWRITE;
        lanes_q <= lanes;
      end
    end
  end

  always_comb begin
    state_n = state;
    RAM_EN  = 1'b0;
    RAM_WE  = 4'b0000;
    RAM_A   = addr_q;
    HRDATA  = 32'h0;
    unique case (state)
      ST_IDLE, ST_READ: begin
        if (state == ST_READ) HRDATA = RAM_Do;
        state_n = ST_IDLE;
        if (accept) begin
          if (HWRITE) begin
            state_n = ST_WRITE;
          end else begin
            RAM_EN  = 1'b1;
            RAM_A   = haddr_w;
            state_n = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        RAM_EN  = 1'b1;
        RAM_WE  = write_q ? lanes_q : 4'b0000;
        state_n = ST_IDLE;
        if (accept) state_n = HWRITE ? ST_WRITE : ST_RAW;
      end
      ST_RAW: begin
        RAM_EN  = 1'b1;
        state_n = ST_READ;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: doc/ahb_dffram_ctrl.md
Name: ahb_dffram_ctrl

Overview:
AHB-Lite slave front end for the SoC's DFFRAM macro. It sits directly upstream of the RAM. It converts AHB address/data phases into the RAM's single-port, registered-read EN/WE/A/Di interface. It generates byte lanes and resolves the read-after-write port conflict with one wait state.

Parameters:
COLS, 1, number of 256-word RAM columns (must match the RAM instance); localparam A_WIDTH = 8 + $clog2(COLS)

Ports:
CLK  in  1  system clock, all logic on posedge
RST  in  1  asynchronous, active-high reset
HSEL  in  1  slave select
HTRANS  in  2  AHB transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HWRITE  in  1  1 = write
HSIZE  in  3  0 = byte, 1 = half, 2 = word; >2 treated as word
HADDR  in  32  byte address; bits [A_WIDTH+1:2] used, others ignored
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-wide ready; address phase sampled only when 1
HREADYOUT  out  1  slave ready
HRDATA  out  32  read data
HRESP  out  1  tied 0 (OKAY)
RAM_EN  out  1  to RAM EN
RAM_WE  out  4  to RAM WE
RAM_A  out  A_WIDTH  to RAM A
RAM_Di  out  32  to RAM Di
RAM_Do  in  32  from RAM Do (valid the cycle after an EN=1 read)

Behaviour:
- Valid address phase: HSEL & HREADY & HTRANS[1]. BUSY/IDLE or HSEL=0 → no RAM access, no state change except return to ST_IDLE after a completed data phase.
- On each valid address phase, register: word address, HWRITE, and byte lanes (lanes from HSIZE and HADDR[1:0]; byte → 1<<HADDR[1:0]; half → 4'b0011<<{HADDR[1],1'b0}; word → 4'b1111).
- States: ST_IDLE, ST_WRITE (write data phase), ST_READ (read data phase, RAM_Do valid), ST_RAW (read pending behind a write).
- Read, RAM idle: in the address phase drive RAM_EN=1, RAM_WE=0, RAM_A=HADDR[A_WIDTH+1:2] combinationally. Next state is ST_READ, where HRDATA=RAM_Do and HREADYOUT=1. Zero wait states.
- Write: the address phase only latches. In ST_WRITE drive RAM_EN=1, RAM_WE=latched lanes, RAM_A=latched address, RAM_Di=HWDATA, HREADYOUT=1. Zero wait states.
- Back-to-back writes: new address latched during ST_WRITE; no stall.
- Read address phase during ST_WRITE: port busy, so latch the read address and go to ST_RAW. ST_RAW drives RAM_EN=1, RAM_WE=0, RAM_A=latched, HREADYOUT=0, then goes to ST_READ. Exactly one wait state on that read.
- Read address phase during ST_READ (pipelined read): issue it combinationally as in the idle case; remain in ST_READ.
- Write address phase during ST_READ: latch only; next state ST_WRITE.
- No new address phase is accepted while HREADYOUT=0. HREADY is 0 in ST_RAW.
- HRDATA = RAM_Do in ST_READ, 32'h0 otherwise. HRESP is always 0.
- RAM_EN=0 and RAM_WE=0 whenever no access is scheduled. Write and read never share a cycle on the RAM.
- Reset (any time, including mid-transfer):
  - state=ST_IDLE, HREADYOUT=1, all latched registers 0, RAM_EN=0, RAM_WE=0.
  - An in-flight write is dropped; no partial write is issued after RST deasserts.

Decomposition:
- Package ahb_dffram_pkg: HTRANS encodings, HSIZE encodings, state enum (ST_IDLE/ST_WRITE/ST_READ/ST_RAW).
- One combinational sub-module ahb_byte_lanes (HSIZE, HADDR[1:0] → 4-bit lanes), shared with other AHB slaves.
- The FSM and registers stay in ahb_dffram_ctrl.

Test Plan:
- Word write then read, addr 0x10, data 0xDEADBEEF:
  - Write: RAM_WE=4'hF and RAM_A=4 in the write data phase.
  - Following read: exactly 1 wait state (HREADYOUT=0 one cycle), then HRDATA=0xDEADBEEF.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23 back-to-back:
  - RAM_WE=1, 2, 4, 8 on consecutive cycles with no wait states.
  - A later word read returns 0x44332211.
- Half write 0xBEEF at 0x32 over word 0x00000000: RAM_WE=4'hC; read of 0x30 returns 0xBEEF0000.
- Four pipelined NONSEQ reads of 0x00, 0x04, 0x08, 0x0C (preloaded 1..4): HRDATA=1, 2, 3, 4 on 4 consecutive cycles, HREADYOUT held 1.
- HTRANS=BUSY, HSEL=0, and HREADY=0 address phases: RAM_EN stays 0 and state stays ST_IDLE.
- RST asserted during ST_RAW: HREADYOUT=1 and RAM_EN=0 immediately. After release, a read of the same address returns its pre-reset contents with no spurious write.
